// File: rtl/cardjitsu_pkg.sv
// Shared encodings for the Card-Jitsu round controller: elements, FSM states,
// round outcomes, status colours and the round-judging helpers.
package cardjitsu_pkg;

  typedef enum logic [1:0] {
    EL_FIRE    = 2'b00,
    EL_WATER   = 2'b01,
    EL_SNOW    = 2'b10,
    EL_INVALID = 2'b11
  } element_t;

  typedef enum logic [1:0] {
    A_SEL,
    B_SEL,
    REVEAL,
    GAME_OVER
  } state_t;

  typedef enum logic [1:0] {
    A_WIN,
    B_WIN,
    TIE
  } outcome_t;

  // Status colours packed as {r, g, b}
  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_WHITE = 3'b111;

  function automatic logic beats(element_t x, element_t y);
    return (x == EL_FIRE  && y == EL_SNOW)  ||
           (x == EL_SNOW  && y == EL_WATER) ||
           (x == EL_WATER && y == EL_FIRE);
  endfunction

  // Cards are {rank[1:0], element[1:0]}; element decides first, rank breaks equal elements
  function automatic outcome_t judge(logic [3:0] a, logic [3:0] b);
    element_t ea;
    element_t eb;
    outcome_t res;
    ea = element_t'(a[1:0]);
    eb = element_t'(b[1:0]);
    if (beats(ea, eb))           res = A_WIN;
    else if (beats(eb, ea))      res = B_WIN;
    else if (a[3:2] > b[3:2])    res = A_WIN;
    else if (a[3:2] < b[3:2])    res = B_WIN;
    else                         res = TIE;
    return res;
  endfunction

  function automatic logic [2:0] elem_rgb(element_t e);
    logic [2:0] c;
    case (e)
      EL_FIRE:  c = RGB_RED;
      EL_WATER: c = RGB_BLUE;
      EL_SNOW:  c = RGB_GREEN;
      default:  c = RGB_OFF;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] reveal_rgb(logic [3:0] a, logic [3:0] b);
    logic [2:0] c;
    case (judge(a, b))
      A_WIN:   c = elem_rgb(element_t'(a[1:0]));
      B_WIN:   c = elem_rgb(element_t'(b[1:0]));
      default: c = RGB_WHITE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cardjitsu_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce filter
// (CARDJITSU_DEBOUNCE_EN) and rising-edge detector giving a 1-cycle pulse.
module cardjitsu_btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync;
  logic [2:0] warm;
  logic       prev;
  logic       lvl;

`ifdef CARDJITSU_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          flt;

  // Filter is preloaded with the first valid synchronized sample so a held button is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      flt <= 1'b0;
    end else if (warm[1] && !warm[2]) begin
      flt <= sync[1];
      cnt <= '0;
    end else if (sync[1] == flt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      flt <= sync[1];
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign lvl = flt;
`else
  assign lvl = sync[1];
`endif

  // prev is held high until the synchronizer has flushed, masking buttons held across reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      warm  <= '0;
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      warm  <= {warm[1:0], 1'b1};
      prev  <= warm[2] ? lvl : 1'b1;
      pulse <= lvl & ~prev;
    end
  end

endmodule

// File: rtl/cardjitsu_round_ctrl.sv
// Card-Jitsu round controller: players A and B commit cards, the result is shown,
// the winner scores; first to WIN_SCORE ends the game. Debounce: CARDJITSU_DEBOUNCE_EN.
module cardjitsu_round_ctrl
  import cardjitsu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REVEAL_CYCLES   = 8,
  parameter int unsigned WIN_SCORE       = 3,
  parameter int unsigned BLINK_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_0,
  input  logic       btn_1,
  input  logic       btn_2,
  input  logic [3:0] sw,
  output logic [3:0] leds,
  output logic       led6_r,
  output logic       led6_g,
  output logic       led6_b
);

  localparam int unsigned RW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [RW-1:0] REVEAL_LAST = RW'(REVEAL_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);
  localparam logic [1:0]    WIN         = 2'(WIN_SCORE);

  logic          pulse_a;
  logic          pulse_b;
  logic          pulse_new;
  state_t        state;
  logic [3:0]    card_a;
  logic [3:0]    card_b;
  logic [1:0]    score_a;
  logic [1:0]    score_b;
  logic [RW-1:0] reveal_cnt;
  logic [BW-1:0] blink_cnt;
  logic [2:0]    status_rgb;
  outcome_t      verdict;
  logic [1:0]    score_a_nx;
  logic [1:0]    score_b_nx;
  logic          game_done;
  logic          sw_valid;

  cardjitsu_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
    .clk(clk), .rst_n(rst), .btn(btn_0), .pulse(pulse_a)
  );
  cardjitsu_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
    .clk(clk), .rst_n(rst), .btn(btn_1), .pulse(pulse_b)
  );
  cardjitsu_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_new (
    .clk(clk), .rst_n(rst), .btn(btn_2), .pulse(pulse_new)
  );

  assign sw_valid = (element_t'(sw[1:0]) != EL_INVALID);

  // Scores saturate at 3 so a WIN_SCORE of 3 can never wrap back to 0
  always_comb begin
    verdict    = judge(card_a, card_b);
    score_a_nx = score_a;
    score_b_nx = score_b;
    if (verdict == A_WIN && score_a != 2'd3) score_a_nx = score_a + 2'd1;
    if (verdict == B_WIN && score_b != 2'd3) score_b_nx = score_b + 2'd1;
    game_done  = (score_a_nx == WIN) || (score_b_nx == WIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= A_SEL;
      card_a     <= '0;
      card_b     <= '0;
      score_a    <= '0;
      score_b    <= '0;
      reveal_cnt <= '0;
      blink_cnt  <= '0;
      status_rgb <= RGB_RED;
    end else begin
      case (state)
        A_SEL: begin
          if (pulse_a && sw_valid) begin
            card_a     <= sw;
            state      <= B_SEL;
            status_rgb <= RGB_BLUE;
          end
        end
        B_SEL: begin
          if (pulse_b && sw_valid) begin
            card_b     <= sw;
            reveal_cnt <= '0;
            state      <= REVEAL;
            status_rgb <= reveal_rgb(card_a, sw);
          end
        end
        REVEAL: begin
          if (reveal_cnt == REVEAL_LAST) begin
            score_a <= score_a_nx;
            score_b <= score_b_nx;
            if (game_done) begin
              state      <= GAME_OVER;
              blink_cnt  <= '0;
              status_rgb <= RGB_GREEN;
            end else begin
              state      <= A_SEL;
              status_rgb <= RGB_RED;
            end
          end else begin
            reveal_cnt <= reveal_cnt + 1'b1;
          end
        end
        GAME_OVER: begin
          if (pulse_new) begin
            score_a    <= '0;
            score_b    <= '0;
            card_a     <= '0;
            card_b     <= '0;
            state      <= A_SEL;
            status_rgb <= RGB_RED;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt     <= '0;
            status_rgb[1] <= ~status_rgb[1];
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        default: state <= A_SEL;
      endcase
    end
  end

  assign leds   = {score_a, score_b};
  assign led6_r = status_rgb[2];
  assign led6_g = status_rgb[1];
  assign led6_b = status_rgb[0];

endmodule
